boton_pulsacion: RTL

Press classifier that sits directly downstream of the debounced-button stage. It takes the clean, debounced button level and turns it into single-cycle event pulses for the mode/state machine:
- a short press, emitted on release;
- a long press, emitted once when the hold time is reached;
- optional auto-repeat pulses while the button stays held after a long press.

One instance is used per physical button.

---
 rtl/boton_pulsacion.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/boton_pulsacion.sv
// boton_pulsacion: classifies a debounced button level into single-cycle
// short-press, long-press and auto-repeat pulses, plus a "press in progress"
// level. One instance per physical button.
//
// Handshake note: there is no valid/ready handshake here. boton_in is a plain
// level sampled on every rising edge, and every output is a registered,
// free-running signal. Pulses are exactly one cycle wide and mutually
// exclusive, so the consumer needs no acknowledge.
module boton_pulsacion #(
  parameter int LARGO_CICLOS   = 50_000_000,
  parameter int REPETIR_CICLOS = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       boton_in,
  output logic       pulso_corto,
  output logic       pulso_largo,
  output logic       pulso_repeticion,
  output logic       presionado,
  output logic [1:0] o_dbg_estado
);

  localparam int HW = $clog2(LARGO_CICLOS + 1);
  localparam int RW = (REPETIR_CICLOS > 0) ? $clog2(REPETIR_CICLOS + 1) : 1;
  localparam logic [HW-1:0] H_MAX  = HW'(LARGO_CICLOS);
  localparam logic [RW-1:0] R_MAX  = RW'(REPETIR_CICLOS);
  localparam bit            REP_EN = (REPETIR_CICLOS != 0);

  localparam logic [1:0] DESARMADO  = 2'd0;
  localparam logic [1:0] REPOSO     = 2'd1;
  localparam logic [1:0] PRESIONADO = 2'd2;
  localparam logic [1:0] LARGO      = 2'd3;

  logic [1:0]    r_estado;
  logic [HW-1:0] r_h;
  logic [RW-1:0] r_r;
  logic          r_corto;
  logic          r_largo;
  logic          r_rep;
  logic          r_pres;

  logic [1:0]    w_estado_sig;
  logic [HW-1:0] w_h_sig;
  logic [RW-1:0] w_r_sig;
  logic          w_corto_sig;
  logic          w_largo_sig;
  logic          w_rep_sig;
  logic [HW-1:0] w_h_inc;
  logic [RW-1:0] w_r_inc;

  // Saturating hold-count increment; the repeat counter never reaches
  // R_MAX before being cleared, so its plain increment cannot wrap.
  assign w_h_inc = (r_h == H_MAX) ? r_h : r_h + HW'(1);
  assign w_r_inc = r_r + RW'(1);

  // Next-state and next-pulse decode for the press classifier.
  always_comb begin
    w_estado_sig = r_estado;
    w_h_sig      = r_h;
    w_r_sig      = r_r;
    w_corto_sig  = 1'b0;
    w_largo_sig  = 1'b0;
    w_rep_sig    = 1'b0;
    case (r_estado)
      DESARMADO: begin
        // A level already high at reset release must be released first.
        if (!boton_in) begin
          w_estado_sig = REPOSO;
        end
      end
      REPOSO: begin
        if (boton_in) begin
          w_estado_sig = PRESIONADO;
          w_h_sig      = HW'(1);
        end
      end
      PRESIONADO: begin
        if (boton_in) begin
          w_h_sig = w_h_inc;
          if (w_h_inc == H_MAX) begin
            w_estado_sig = LARGO;
            w_largo_sig  = 1'b1;
            w_r_sig      = '0;
          end
        end else begin
          w_estado_sig = REPOSO;
          w_h_sig      = '0;
          w_corto_sig  = 1'b1;
        end
      end
      LARGO: begin
        if (boton_in) begin
          if (REP_EN) begin
            if (w_r_inc == R_MAX) begin
              w_rep_sig = 1'b1;
              w_r_sig   = '0;
            end else begin
              w_r_sig = w_r_inc;
            end
          end
        end else begin
          // Releasing a long press ends it silently.
          w_estado_sig = REPOSO;
          w_h_sig      = '0;
          w_r_sig      = '0;
        end
      end
      default: begin
        w_estado_sig = DESARMADO;
        w_h_sig      = '0;
        w_r_sig      = '0;
      end
    endcase
  end

  // State, counters and registered outputs; reset drops everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= DESARMADO;
      r_h      <= '0;
      r_r      <= '0;
      r_corto  <= 1'b0;
      r_largo  <= 1'b0;
      r_rep    <= 1'b0;
      r_pres   <= 1'b0;
    end else begin
      r_estado <= w_estado_sig;
      r_h      <= w_h_sig;
      r_r      <= w_r_sig;
      r_corto  <= w_corto_sig;
      r_largo  <= w_largo_sig;
      r_rep    <= w_rep_sig;
      r_pres   <= (w_estado_sig == PRESIONADO) || (w_estado_sig == LARGO);
    end
  end

  assign pulso_corto      = r_corto;
  assign pulso_largo      = r_largo;
  assign pulso_repeticion = r_rep;
  assign presionado       = r_pres;
  assign o_dbg_estado     = r_estado;

endmodule
